// File: rtl/program_counter_if.sv
// Control and status bundle between the control unit (master) and the
// program counter (slave). The tri-stated address pin is not part of it.
interface program_counter_if #(
  parameter int AW    = 16,
  parameter int DEPTH = 8
);
  logic                   pc_w;
  logic                   pc_r;
  logic                   pc_rst;
  logic                   pc_inc;
  logic                   pc_push;
  logic                   pc_pop;
  logic [AW-1:0]          addr_bus_in;
  logic [AW-1:0]          pc_value;
  logic [$clog2(DEPTH):0] stk_depth;
  logic                   stk_full;
  logic                   stk_empty;
  logic                   stk_ovf;
  logic                   stk_unf;

  modport master (
    output pc_w, pc_r, pc_rst, pc_inc, pc_push, pc_pop, addr_bus_in,
    input  pc_value, stk_depth, stk_full, stk_empty, stk_ovf, stk_unf
  );

  modport slave (
    input  pc_w, pc_r, pc_rst, pc_inc, pc_push, pc_pop, addr_bus_in,
    output pc_value, stk_depth, stk_full, stk_empty, stk_ovf, stk_unf
  );
endinterface

// File: rtl/program_counter.sv
// Program counter with a LIFO return stack for CALL/RET.
// PC op priority: rst > pc_rst > pc_pop > pc_w > pc_inc; pc_push runs
// alongside the PC op and always stores the PC held before the edge.
module program_counter #(
  parameter int AW    = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  program_counter_if.slave bus,
  output logic [AW-1:0]    addr_bus_out
);
  localparam int PW = $clog2(DEPTH);
  localparam int DW = PW + 1;

  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  // Entry contents carry no reset; depth alone marks which are valid.
  logic [AW-1:0] stack_q [DEPTH];
  logic          wr_en;
  logic [PW-1:0] wr_idx;
  logic [PW-1:0] top_idx;
  logic          full;
  logic          empty;

  assign full    = (depth_q == DW'(DEPTH));
  assign empty   = (depth_q == '0);
  assign top_idx = PW'(depth_q - DW'(1));

  // Next-state: PC op by priority, stack push/pop/swap, sticky error flags
  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    wr_idx  = PW'(depth_q);

    if (bus.pc_pop) begin
      // An empty pop (with or without push) only raises underflow and
      // suppresses every lower-priority PC op this cycle.
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        pc_d = stack_q[top_idx];
        if (bus.pc_push) begin
          // Swap: return address out, old PC into the same slot.
          wr_en  = 1'b1;
          wr_idx = top_idx;
        end else begin
          depth_d = depth_q - DW'(1);
        end
      end
    end else begin
      if (bus.pc_w) begin
        pc_d = bus.addr_bus_in;
      end else if (bus.pc_inc) begin
        pc_d = pc_q + AW'(1);
      end
      if (bus.pc_push) begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          wr_en   = 1'b1;
          depth_d = depth_q + DW'(1);
        end
      end
    end

    // Soft clear overrides everything issued in the same cycle.
    if (bus.pc_rst || rst) begin
      pc_d    = '0;
      depth_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      wr_en   = 1'b0;
    end
  end

  // PC, depth and flag registers with synchronous hard reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage: one write port, always storing the pre-edge PC
  always_ff @(posedge clk) begin
    if (wr_en) begin
      stack_q[wr_idx] <= pc_q;
    end
  end

  assign bus.pc_value  = pc_q;
  assign bus.stk_depth = depth_q;
  assign bus.stk_full  = full;
  assign bus.stk_empty = empty;
  assign bus.stk_ovf   = ovf_q;
  assign bus.stk_unf   = unf_q;

  // Shared address bus: released whenever the PC is not selected.
  assign addr_bus_out = bus.pc_r ? pc_q : {AW{1'bz}};
endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed scenarios plus a
// randomized run checked against a queue-based return-stack model.
module tb_program_counter;
  localparam int AW    = 16;
  localparam int DEPTH = 8;
  localparam int DW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  wire  [AW-1:0] addr_bus_out;

  program_counter_if #(.AW(AW), .DEPTH(DEPTH)) bus_if ();

  program_counter #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus_if),
    .addr_bus_out (addr_bus_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: PC, return stack as a queue, sticky flags
  logic [AW-1:0] m_pc = '0;
  logic [AW-1:0] m_stk [$];
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;
  logic [AW-1:0] z_val;

  task automatic model_step(input bit clr, pop, push, w, inc, input logic [AW-1:0] din);
    logic [AW-1:0] old;
    old = m_pc;
    if (clr) begin
      m_pc = '0;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (pop) begin
      if (m_stk.size() == 0) begin
        m_unf = 1'b1;
      end else begin
        m_pc = m_stk.pop_back();
        if (push) m_stk.push_back(old);
      end
    end else begin
      if (w) m_pc = din;
      else if (inc) m_pc = old + 1'b1;
      if (push) begin
        if (m_stk.size() == DEPTH) m_ovf = 1'b1;
        else m_stk.push_back(old);
      end
    end
  endtask

  // One clock: drive on negedge, model on posedge, return at next negedge
  task automatic cyc(input bit r, pr, pop, push, w, inc, input logic [AW-1:0] din);
    rst                = r;
    bus_if.pc_rst      = pr;
    bus_if.pc_pop      = pop;
    bus_if.pc_push     = push;
    bus_if.pc_w        = w;
    bus_if.pc_inc      = inc;
    bus_if.addr_bus_in = din;
    @(posedge clk);
    model_step(r | pr, pop, push, w, inc, din);
    @(negedge clk);
    $display("cyc t=%0t rst=%b prst=%b pop=%b push=%b w=%b inc=%b din=%h -> pc=%h depth=%0d ovf=%b unf=%b",
             $time, r, pr, pop, push, w, inc, din, bus_if.pc_value, bus_if.stk_depth,
             bus_if.stk_ovf, bus_if.stk_unf);
    rst                = 1'b0;
    bus_if.pc_rst      = 1'b0;
    bus_if.pc_pop      = 1'b0;
    bus_if.pc_push     = 1'b0;
    bus_if.pc_w        = 1'b0;
    bus_if.pc_inc      = 1'b0;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 0, 0, '0);
    n_vec++; if (bus_if.pc_value !== 16'h0000) begin n_err++; $display("FAIL reset_pc got %h want 0000", bus_if.pc_value); end
    n_vec++; if (bus_if.stk_depth !== DW'(0)) begin n_err++; $display("FAIL reset_depth got %0d want 0", bus_if.stk_depth); end
    n_vec++; if (bus_if.stk_empty !== 1'b1 || bus_if.stk_full !== 1'b0) begin n_err++; $display("FAIL reset_empty_full got e=%b f=%b want e=1 f=0", bus_if.stk_empty, bus_if.stk_full); end
    n_vec++; if (bus_if.stk_ovf !== 1'b0 || bus_if.stk_unf !== 1'b0) begin n_err++; $display("FAIL reset_flags got ovf=%b unf=%b want 0 0", bus_if.stk_ovf, bus_if.stk_unf); end
  endtask

  task automatic test_inc_bus();
    cyc(1, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, '0);
    n_vec++; if (bus_if.pc_value !== 16'h0003) begin n_err++; $display("FAIL inc3_pc got %h want 0003", bus_if.pc_value); end
    bus_if.pc_r = 1'b1; #1;
    n_vec++; if (addr_bus_out !== 16'h0003) begin n_err++; $display("FAIL bus_drive got %h want 0003", addr_bus_out); end
    bus_if.pc_r = 1'b0; #1;
    n_vec++; if (addr_bus_out !== z_val) begin n_err++; $display("FAIL bus_release got %h want %h", addr_bus_out, z_val); end
  endtask

  task automatic test_call_ret();
    cyc(1, 0, 0, 0, 0, 0, '0);
    cyc(0, 0, 0, 0, 1, 0, 16'h0010);
    cyc(0, 0, 0, 1, 1, 0, 16'h1234);
    n_vec++; if (bus_if.pc_value !== 16'h1234 || bus_if.stk_depth !== DW'(1)) begin n_err++; $display("FAIL call got pc=%h depth=%0d want 1234 1", bus_if.pc_value, bus_if.stk_depth); end
    cyc(0, 0, 1, 0, 0, 0, '0);
    n_vec++; if (bus_if.pc_value !== 16'h0010 || bus_if.stk_depth !== DW'(0) || bus_if.stk_empty !== 1'b1) begin n_err++; $display("FAIL ret got pc=%h depth=%0d empty=%b want 0010 0 1", bus_if.pc_value, bus_if.stk_depth, bus_if.stk_empty); end
  endtask

  task automatic test_wrap();
    cyc(1, 0, 0, 0, 0, 0, '0);
    cyc(0, 0, 0, 0, 1, 0, 16'hFFFF);
    cyc(0, 0, 0, 0, 0, 1, '0);
    n_vec++; if (bus_if.pc_value !== 16'h0000) begin n_err++; $display("FAIL wrap_pc got %h want 0000", bus_if.pc_value); end
    n_vec++; if (bus_if.stk_ovf !== 1'b0 || bus_if.stk_unf !== 1'b0) begin n_err++; $display("FAIL wrap_flags got ovf=%b unf=%b want 0 0", bus_if.stk_ovf, bus_if.stk_unf); end
  endtask

  task automatic test_overflow_lifo();
    logic [AW-1:0] d [9];
    logic [AW-1:0] s [8];
    cyc(1, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 9; i++) begin
      d[i] = 16'(32'h100 + i * 32'h11 + ($urandom & 32'hF000));
      cyc(0, 0, 0, 1, 1, 0, d[i]);
    end
    // Stored return addresses: 0 after reset, then each loaded value in turn.
    s[0] = '0;
    for (int k = 1; k < 8; k++) s[k] = d[k-1];
    n_vec++; if (bus_if.stk_depth !== DW'(8) || bus_if.stk_full !== 1'b1 || bus_if.stk_ovf !== 1'b1) begin n_err++; $display("FAIL ovf got depth=%0d full=%b ovf=%b want 8 1 1", bus_if.stk_depth, bus_if.stk_full, bus_if.stk_ovf); end
    n_vec++; if (bus_if.pc_value !== d[8]) begin n_err++; $display("FAIL ovf_pc_op got %h want %h", bus_if.pc_value, d[8]); end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 0, 0, 0, '0);
      n_vec++; if (bus_if.pc_value !== s[7-i]) begin n_err++; $display("FAIL lifo_pop%0d got %h want %h", i, bus_if.pc_value, s[7-i]); end
    end
    cyc(0, 0, 1, 0, 1, 1, 16'h5555);
    n_vec++; if (bus_if.pc_value !== s[0] || bus_if.stk_unf !== 1'b1 || bus_if.stk_depth !== DW'(0)) begin n_err++; $display("FAIL unf got pc=%h unf=%b depth=%0d want %h 1 0", bus_if.pc_value, bus_if.stk_unf, bus_if.stk_depth, s[0]); end
  endtask

  task automatic test_swap();
    cyc(1, 0, 0, 0, 0, 0, '0);
    cyc(0, 0, 0, 0, 1, 0, 16'h0200);
    cyc(0, 0, 0, 1, 1, 0, 16'h0100);
    cyc(0, 0, 1, 1, 0, 0, '0);
    n_vec++; if (bus_if.pc_value !== 16'h0200 || bus_if.stk_depth !== DW'(1)) begin n_err++; $display("FAIL swap got pc=%h depth=%0d want 0200 1", bus_if.pc_value, bus_if.stk_depth); end
    cyc(0, 0, 1, 0, 0, 0, '0);
    n_vec++; if (bus_if.pc_value !== 16'h0100) begin n_err++; $display("FAIL swap_top got %h want 0100", bus_if.pc_value); end
    cyc(0, 0, 1, 1, 1, 0, 16'h7777);
    n_vec++; if (bus_if.pc_value !== 16'h0100 || bus_if.stk_unf !== 1'b1 || bus_if.stk_depth !== DW'(0)) begin n_err++; $display("FAIL swap_empty got pc=%h unf=%b depth=%0d want 0100 1 0", bus_if.pc_value, bus_if.stk_unf, bus_if.stk_depth); end
  endtask

  task automatic test_soft_reset();
    cyc(1, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 1, 0, 1, '0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0, '0);
    n_vec++; if (bus_if.stk_depth !== DW'(5) || bus_if.stk_ovf !== 1'b1) begin n_err++; $display("FAIL prst_setup got depth=%0d ovf=%b want 5 1", bus_if.stk_depth, bus_if.stk_ovf); end
    cyc(0, 1, 0, 1, 1, 0, 16'hABCD);
    n_vec++; if (bus_if.pc_value !== 16'h0000 || bus_if.stk_depth !== DW'(0) || bus_if.stk_ovf !== 1'b0 || bus_if.stk_empty !== 1'b1) begin n_err++; $display("FAIL prst got pc=%h depth=%0d ovf=%b empty=%b want 0000 0 0 1", bus_if.pc_value, bus_if.stk_depth, bus_if.stk_ovf, bus_if.stk_empty); end
  endtask

  task automatic test_random();
    bit r, pr, pop, push, w, inc;
    cyc(1, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 300; i++) begin
      r    = ($urandom_range(0, 63) == 0);
      pr   = ($urandom_range(0, 31) == 0);
      pop  = ($urandom_range(0, 2) == 0);
      push = ($urandom_range(0, 1) == 0);
      w    = ($urandom_range(0, 2) == 0);
      inc  = ($urandom_range(0, 1) == 0);
      cyc(r, pr, pop, push, w, inc, 16'($urandom));
      n_vec++; if (bus_if.pc_value !== m_pc) begin n_err++; $display("FAIL rand_pc #%0d got %h want %h", i, bus_if.pc_value, m_pc); end
      n_vec++; if (bus_if.stk_depth !== DW'(m_stk.size())) begin n_err++; $display("FAIL rand_depth #%0d got %0d want %0d", i, bus_if.stk_depth, m_stk.size()); end
      n_vec++; if (bus_if.stk_full !== (m_stk.size() == DEPTH) || bus_if.stk_empty !== (m_stk.size() == 0)) begin n_err++; $display("FAIL rand_fe #%0d got f=%b e=%b want f=%b e=%b", i, bus_if.stk_full, bus_if.stk_empty, m_stk.size() == DEPTH, m_stk.size() == 0); end
      n_vec++; if (bus_if.stk_ovf !== m_ovf || bus_if.stk_unf !== m_unf) begin n_err++; $display("FAIL rand_flags #%0d got ovf=%b unf=%b want %b %b", i, bus_if.stk_ovf, bus_if.stk_unf, m_ovf, m_unf); end
      bus_if.pc_r = 1'($urandom_range(0, 1)); #1;
      if (bus_if.pc_r) begin
        n_vec++; if (addr_bus_out !== m_pc) begin n_err++; $display("FAIL rand_bus #%0d got %h want %h", i, addr_bus_out, m_pc); end
      end
      bus_if.pc_r = 1'b0;
    end
  endtask

  initial begin
    z_val              = {AW{1'bz}};
    bus_if.pc_r        = 1'b0;
    bus_if.pc_w        = 1'b0;
    bus_if.pc_rst      = 1'b0;
    bus_if.pc_inc      = 1'b0;
    bus_if.pc_push     = 1'b0;
    bus_if.pc_pop      = 1'b0;
    bus_if.addr_bus_in = '0;
    @(negedge clk);
    test_reset();
    test_inc_bus();
    test_call_ret();
    test_wrap();
    test_overflow_lifo();
    test_swap();
    test_soft_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 SHALL have parameter AW, default 16: address width, matching addr_bus width.
REQ-002 SHALL have parameter DEPTH, default 8: return-stack entries; DEPTH SHALL be a power of two, 2..16.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pc_w  input  1  load PC from addr_bus_in.
REQ-006 SHALL have port pc_r  input  1  drive PC onto addr_bus_out.
REQ-007 SHALL have port pc_rst  input  1  synchronous soft clear of PC and stack.
REQ-008 SHALL have port pc_inc  input  1  PC <- PC + 1.
REQ-009 SHALL have port pc_push  input  1  push the current PC onto the return stack (CALL).
REQ-010 SHALL have port pc_pop  input  1  pop the stack top into PC (RET).
REQ-011 SHALL have port addr_bus_in  input  AW  load value for pc_w.
REQ-012 SHALL have port addr_bus_out  output  AW  PC when pc_r=1, else all-Z.
REQ-013 SHALL have port pc_value  output  AW  current PC, always driven.
REQ-014 SHALL have port stk_depth  output  $clog2(DEPTH)+1  number of valid stack entries.
REQ-015 SHALL have port stk_full / stk_empty  output  1 each  depth==DEPTH / depth==0.
REQ-016 SHALL have port stk_ovf / stk_unf  output  1 each  sticky overflow / underflow flags.

Function
REQ-017 Controls are driven by the control unit on negedge clk; this block SHALL sample them only on posedge clk.
REQ-018 addr_bus_out SHALL be combinational from pc_r, with no cycle delay.
REQ-019 PC update priority per cycle SHALL be: rst > pc_rst > pc_pop > pc_w > pc_inc; lower-priority PC ops in the same cycle SHALL be ignored.
REQ-020 pc_inc SHALL wrap from 2^AW-1 to 0, with no flag.
REQ-021 pc_push SHALL write the PC value held before this edge into stack[depth] and increment depth; it is independent of the PC update priority.
REQ-022 pc_push with pc_w in the same cycle SHALL push the old PC and load addr_bus_in (atomic CALL).
REQ-023 pc_push with pc_inc in the same cycle SHALL push the pre-increment PC.
REQ-024 pc_pop with depth>0 SHALL load stack[depth-1] into PC and decrement depth.
REQ-025 pc_push when full SHALL leave the stack and depth unchanged and set stk_ovf; the concurrent PC op SHALL still execute.
REQ-026 pc_pop when empty SHALL leave PC and depth unchanged and set stk_unf; no lower-priority PC op SHALL execute that cycle.
REQ-027 pc_push and pc_pop in the same cycle with depth>0 SHALL load PC from the top entry, overwrite that entry with the old PC, and keep depth unchanged (swap).
REQ-028 pc_push and pc_pop in the same cycle with depth=0 SHALL set stk_unf only; PC and depth SHALL be unchanged.
REQ-029 stk_ovf and stk_unf SHALL stay set until rst or pc_rst.
REQ-030 Stack entry contents SHALL need no reset; only depth defines validity.

Reset
REQ-031 On rst, or on pc_rst at posedge clk, the block SHALL set PC=0, depth=0, stk_ovf=0 and stk_unf=0.
REQ-032 After reset: pc_value=0, stk_empty=1, stk_full=0, stk_depth=0; addr_bus_out SHALL follow pc_r (Z when pc_r=0).
REQ-033 rst or pc_rst asserted mid-sequence (e.g. coincident with pc_push/pc_w) SHALL override every other control in that cycle.

Verification
REQ-034 Reset, then 3 cycles of pc_inc -> pc_value=0x0003; pc_r=1 gives addr_bus_out=0x0003; pc_r=0 gives Z.
REQ-035 PC=0x0010, pc_push+pc_w with addr_bus_in=0x1234 -> PC=0x1234, depth=1; then pc_pop -> PC=0x0010, depth=0, stk_empty=1.
REQ-036 pc_w with addr_bus_in=0xFFFF, then pc_inc -> PC=0x0000, no flags set.
REQ-037 9 pushes with DEPTH=8 -> depth=8, stk_full=1, stk_ovf=1; then 8 pops return the 8 stored values in LIFO order; a 9th pop -> PC unchanged, stk_unf=1.
REQ-038 PC=0x0100 with stack top 0x0200, pc_push+pc_pop together -> PC=0x0200, top=0x0100, depth unchanged.
REQ-039 pc_rst together with pc_push and pc_w while depth=5 and stk_ovf=1 -> PC=0, depth=0, stk_ovf=0.
